// File: rtl/ann_input_router.sv
// Loads neuron input channels from feature/logsig/zero sources by broadcast or scatter; oData updates one cycle after an accepted beat.
// oReady depends only on the registered state, so iValid has no combinational path to it; beats offered while oReady is low are dropped.
module ann_input_router #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 20,
  parameter int CH_W   = $clog2(N_CH)
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iStart,
  input  logic                     iMode,
  input  logic [1:0]               iSel,
  input  logic [DATA_W-1:0]        iFeature,
  input  logic [DATA_W-1:0]        iOutput_Logsig,
  input  logic                     iValid,
  output logic                     oReady,
  output logic [N_CH*DATA_W-1:0]   oData,
  output logic [CH_W-1:0]          oCh_idx,
  output logic                     oBusy,
  output logic                     oDone
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BCAST   = 2'd1,
    S_SCATTER = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [N_CH*DATA_W-1:0]   data_q, data_d;
  logic [CH_W-1:0]          ch_idx_q, ch_idx_d;
  logic [DATA_W-1:0]        word;
  logic                     accept;

  always_comb begin
    word = '0;
    case (iSel)
      2'b00:   word = iFeature;
      2'b01:   word = iOutput_Logsig;
      default: word = '0;
    endcase
  end

  assign oReady  = (state_q == S_BCAST) || (state_q == S_SCATTER);
  assign oBusy   = (state_q != S_IDLE);
  assign oDone   = (state_q == S_DONE);
  assign oData   = data_q;
  assign oCh_idx = ch_idx_q;
  assign accept  = iValid && oReady;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    ch_idx_d = ch_idx_q;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d  = iMode ? S_SCATTER : S_BCAST;
          ch_idx_d = '0;
        end
      end
      S_BCAST: begin
        if (accept) begin
          for (int k = 0; k < N_CH; k++) begin
            data_d[k*DATA_W +: DATA_W] = word;
          end
          state_d = S_DONE;
        end
      end
      S_SCATTER: begin
        if (accept) begin
          for (int k = 0; k < N_CH; k++) begin
            if (ch_idx_q == CH_W'(k)) begin
              data_d[k*DATA_W +: DATA_W] = word;
            end
          end
          // Last channel closes the pass and rewinds the index.
          if (ch_idx_q == CH_W'(N_CH-1)) begin
            ch_idx_d = '0;
            state_d  = S_DONE;
          end else begin
            ch_idx_d = ch_idx_q + CH_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      ch_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      ch_idx_q <= ch_idx_d;
    end
  end

endmodule

// File: tb/tb_ann_input_router.sv
// Scoreboard bench for ann_input_router: reference model pushes expected oData on each accepted beat, monitor pops it a cycle later.
module tb_ann_input_router;
  localparam int DW   = 32;
  localparam int N_CH = 20;
  localparam int CW   = $clog2(N_CH);
  localparam int W    = N_CH*DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [1:0]    sel = 2'b00;
  logic [DW-1:0] feat = '0;
  logic [DW-1:0] logsig = '0;
  logic          valid = 1'b0;
  logic          rdy;
  logic [W-1:0]  data;
  logic [CW-1:0] ch_idx;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int d0;

  int            m_state = 0;
  int            m_idx = 0;
  logic [W-1:0]  m_data = '0;
  logic [DW-1:0] m_w;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_v;

  ann_input_router #(.DATA_W(DW), .N_CH(N_CH)) dut (
    .iClk(clk), .iRst(rst), .iStart(start), .iMode(mode), .iSel(sel),
    .iFeature(feat), .iOutput_Logsig(logsig), .iValid(valid),
    .oReady(rdy), .oData(data), .oCh_idx(ch_idx), .oBusy(busy), .oDone(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: 0 idle, 1 broadcast, 2 scatter, 3 done.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0;
      m_idx   = 0;
      m_data  = '0;
      exp_q.delete();
    end else begin
      m_w = (sel == 2'b00) ? feat : (sel == 2'b01) ? logsig : '0;
      case (m_state)
        0: if (start) begin m_state = mode ? 2 : 1; m_idx = 0; end
        1: if (valid) begin
             for (int k = 0; k < N_CH; k++) m_data[k*DW +: DW] = m_w;
             exp_q.push_back(m_data);
             m_state = 3;
           end
        2: if (valid) begin
             m_data[m_idx*DW +: DW] = m_w;
             exp_q.push_back(m_data);
             if (m_idx == N_CH-1) begin m_idx = 0; m_state = 3; end
             else m_idx++;
           end
        default: m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    chk("ready", W'(rdy),    W'(m_state == 1 || m_state == 2));
    chk("busy",  W'(busy),   W'(m_state != 0));
    chk("done",  W'(done),   W'(m_state == 3));
    chk("chidx", W'(ch_idx), W'(m_idx));
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      chk("odata", data, exp_v);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m);
    start = 1'b1;
    mode  = m;
    step(1);
    start = 1'b0;
    mode  = ~m;
  endtask

  task automatic beat(input logic [1:0] s, input logic [DW-1:0] w, input int gap);
    valid  = 1'b1;
    sel    = s;
    feat   = (s == 2'b00) ? w : ~w;
    logsig = (s == 2'b01) ? w : ~w;
    if (s[1]) begin feat = $urandom; logsig = $urandom; end
    step(1);
    valid = 1'b0;
    sel   = $urandom_range(0, 3);
    if (gap > 0) step(gap);
  endtask

  task automatic chk_all(input string tag, input logic [DW-1:0] w);
    for (int k = 0; k < N_CH; k++) chk(tag, W'(data[k*DW +: DW]), W'(w));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_data",  data,       '0);
    chk("rst_ready", W'(rdy),    '0);
    chk("rst_busy",  W'(busy),   '0);
    chk("rst_done",  W'(done),   '0);
    chk("rst_idx",   W'(ch_idx), '0);
    step(2);
    rst = 1'b0;
    step(2);

    // Broadcast of 1.0f from the feature source.
    d0 = done_cnt;
    do_start(1'b0);
    beat(2'b00, 32'h3F800000, 0);
    chk_all("bcast_ch", 32'h3F800000);
    step(1);
    chk("bcast_done", W'(done_cnt - d0), W'(1));
    chk("bcast_busy", W'(busy), '0);

    // Scatter of logsig words with every third cycle idle.
    d0 = done_cnt;
    do_start(1'b1);
    for (int k = 0; k < N_CH; k++) begin
      if (k == N_CH-1) chk("scat_idx19", W'(ch_idx), W'(19));
      beat(2'b01, DW'(k+1), (k % 2 == 1) ? 1 : 0);
    end
    chk("scat_wrap", W'(ch_idx), '0);
    for (int k = 0; k < N_CH; k++) chk("scat_ch", W'(data[k*DW +: DW]), W'(k+1));
    step(2);
    chk("scat_done", W'(done_cnt - d0), W'(1));

    // Mixed select: sources 10/11 load zero.
    do_start(1'b1);
    for (int k = 0; k < N_CH; k++) beat(2'(k % 4), DW'(32'h1000 + k), k % 3);
    for (int k = 0; k < N_CH; k++)
      chk("mix_ch", W'(data[k*DW +: DW]), (k % 4 >= 2) ? '0 : W'(32'h1000 + k));
    step(2);

    // iStart during scatter and iValid in idle are ignored.
    do_start(1'b1);
    for (int k = 0; k < 3; k++) beat(2'b01, DW'(32'h100 + k), 0);
    start = 1'b1; mode = 1'b0;
    step(1);
    start = 1'b0;
    chk("ign_idx",  W'(ch_idx), W'(3));
    chk("ign_busy", W'(busy), W'(1));
    for (int k = 3; k < N_CH; k++) beat(2'b01, DW'(32'h100 + k), 0);
    step(2);
    valid = 1'b1; sel = 2'b00; feat = 32'h55555555;
    step(5);
    valid = 1'b0;
    chk("ign_rdy", W'(rdy), '0);
    chk("ign_idle_idx", W'(ch_idx), '0);
    for (int k = 0; k < N_CH; k++) chk("ign_hold", W'(data[k*DW +: DW]), W'(32'h100 + k));

    // Reset after 7 scatter beats discards the pass.
    d0 = done_cnt;
    do_start(1'b1);
    for (int k = 0; k < 7; k++) beat(2'b01, DW'(32'h77 + k), 0);
    rst = 1'b1;
    step(1);
    chk("mrst_data", data, '0);
    chk("mrst_idx",  W'(ch_idx), '0);
    rst = 1'b0;
    step(3);
    chk("mrst_nodone", W'(done_cnt - d0), '0);
    d0 = done_cnt;
    do_start(1'b0);
    beat(2'b00, 32'hDEADBEEF, 0);
    chk_all("dead_ch", 32'hDEADBEEF);
    step(2);
    chk("dead_done", W'(done_cnt - d0), W'(1));

    // Reset after zero scatter beats clears, then a broadcast holds through idle.
    do_start(1'b0);
    beat(2'b00, 32'hAAAAAAAA, 1);
    do_start(1'b1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_all("hold_rst", 32'h0);
    step(1);
    do_start(1'b0);
    beat(2'b00, 32'hAAAAAAAA, 0);
    step(50);
    chk_all("hold_ch", 32'hAAAAAAAA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
